// File: rtl/mca_control_sequencer.sv
// -----------------------------------------------------------------------------
// mca_control_sequencer
//
// Upstream stage of the multi-cycle FIR adder tree. Shifts accepted N-bit
// control vectors into a K-entry history (K/N lookback steps x N channels).
// Every DSR-th accepted vector it freezes the history onto S_matrix and
// pulses start. Starts are spaced by at least CALC_CYCLES enabled cycles.
// A sample boundary that arrives while the tree is still busy is dropped
// and flagged on the sticky overrun output.
//
// Optional build macro: MCA_SEQ_WARMUP_EN
//   When defined, boundaries are suppressed until K/N vectors have been
//   accepted, and the extra output 'warm' reports a filled history.
//
// Ports:
//   clk           in   clock
//   resetn        in   synchronous active-low reset
//   enable        in   global run enable; 0 freezes all counters/history
//   s_in          in   [N-1:0] control vector, bit n = channel n
//   s_valid       in   s_in valid this cycle
//   clear_overrun in   clears the sticky overrun flag
//   S_matrix      out  [K-1:0] unpacked frozen history snapshot
//   start         out  one-cycle pulse, new computation
//   busy          out  adder tree computation window active
//   overrun       out  sticky, a sample boundary was dropped
//   sample_count  out  [CNT_WIDTH-1:0] starts issued, wraps
//   warm          out  (MCA_SEQ_WARMUP_EN only) history fully populated
// -----------------------------------------------------------------------------
module mca_control_sequencer #(
    parameter int unsigned K           = 256,
    parameter int unsigned N           = 8,
    parameter int unsigned DSR         = 8,
    parameter int unsigned CALC_CYCLES = 16,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic [N-1:0]         s_in,
    input  logic                 s_valid,
    input  logic                 clear_overrun,
    output logic                 S_matrix [K-1:0],
    output logic                 start,
    output logic                 busy,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] sample_count
`ifdef MCA_SEQ_WARMUP_EN
    ,
    output logic                 warm
`endif
);

    localparam int unsigned STEPS  = K / N;
    localparam int unsigned DS_W   = (DSR > 1) ? $clog2(DSR) : 1;
    localparam int unsigned BUSY_W = $clog2(CALC_CYCLES + 1);

    logic [K-1:0]      hist;
    logic [K-1:0]      hist_shifted;
    logic [K-1:0]      snap;
    logic [DS_W-1:0]   ds_cnt;
    logic [BUSY_W-1:0] busy_cnt;

    logic accept;
    logic ds_last;
    logic boundary;
    logic launch;
    logic ovr_set;
    logic armed;

`ifdef MCA_SEQ_WARMUP_EN
    localparam int unsigned FILL_W = $clog2(STEPS + 1);
    logic [FILL_W-1:0] fill;

    // The vector accepted this cycle counts toward the fill, so the boundary
    // that completes the K/N-th accept is already allowed through.
    assign armed = (fill >= FILL_W'(STEPS - 1));
    assign warm  = (fill == FILL_W'(STEPS));
`else
    assign armed = 1'b1;
`endif

    always_comb begin
        // Shift every lookback step one place toward the MSBs; the current
        // vector lands in step 0.
        hist_shifted          = hist << N;
        hist_shifted[N-1:0]   = s_in;
    end

    always_comb begin
        accept   = enable & s_valid;
        ds_last  = (ds_cnt == DS_W'(DSR - 1));
        boundary = accept & ds_last & armed;
        launch   = boundary & (busy_cnt == '0);
        ovr_set  = boundary & (busy_cnt != '0);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hist         <= '0;
            snap         <= '0;
            ds_cnt       <= '0;
            busy_cnt     <= '0;
            start        <= 1'b0;
            overrun      <= 1'b0;
            sample_count <= '0;
`ifdef MCA_SEQ_WARMUP_EN
            fill         <= '0;
`endif
        end else begin
            start <= launch;

            if (accept) begin
                hist   <= hist_shifted;
                ds_cnt <= ds_last ? '0 : ds_cnt + DS_W'(1);
`ifdef MCA_SEQ_WARMUP_EN
                if (fill != FILL_W'(STEPS))
                    fill <= fill + FILL_W'(1);
`endif
            end

            // Reload takes priority over the per-cycle countdown.
            if (launch) begin
                snap         <= hist_shifted;
                busy_cnt     <= BUSY_W'(CALC_CYCLES);
                sample_count <= sample_count + CNT_WIDTH'(1);
            end else if (enable && busy_cnt != '0) begin
                busy_cnt <= busy_cnt - BUSY_W'(1);
            end

            if (ovr_set)
                overrun <= 1'b1;
            else if (clear_overrun)
                overrun <= 1'b0;
        end
    end

    assign busy = (busy_cnt != '0);

    always_comb begin
        for (int unsigned i = 0; i < K; i++)
            S_matrix[i] = snap[i];
    end

endmodule

// File: tb/tb_mca_control_sequencer.sv
module tb_mca_control_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic [1:0] s_in;
    logic       s_valid;
    logic       clear_overrun;

    // dut_a: CALC_CYCLES=3, dut_b: CALC_CYCLES=5, same stimulus
    logic        S_a [7:0];
    logic        S_b [7:0];
    logic        start_a, busy_a, ovr_a;
    logic        start_b, busy_b, ovr_b;
    logic [15:0] cnt_a, cnt_b;
    logic [7:0]  pk_a, pk_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

`ifdef MCA_SEQ_WARMUP_EN
    logic        warm_a, warm_b, warm_c;
    logic        S_c [7:0];
    logic        start_c, busy_c, ovr_c;
    logic [15:0] cnt_c;
`endif

    mca_control_sequencer #(
        .K(8), .N(2), .DSR(4), .CALC_CYCLES(3), .CNT_WIDTH(16)
    ) dut_a (
        .clk(clk), .resetn(resetn), .enable(enable), .s_in(s_in),
        .s_valid(s_valid), .clear_overrun(clear_overrun),
        .S_matrix(S_a), .start(start_a), .busy(busy_a),
        .overrun(ovr_a), .sample_count(cnt_a)
`ifdef MCA_SEQ_WARMUP_EN
        , .warm(warm_a)
`endif
    );

    mca_control_sequencer #(
        .K(8), .N(2), .DSR(4), .CALC_CYCLES(5), .CNT_WIDTH(16)
    ) dut_b (
        .clk(clk), .resetn(resetn), .enable(enable), .s_in(s_in),
        .s_valid(s_valid), .clear_overrun(clear_overrun),
        .S_matrix(S_b), .start(start_b), .busy(busy_b),
        .overrun(ovr_b), .sample_count(cnt_b)
`ifdef MCA_SEQ_WARMUP_EN
        , .warm(warm_b)
`endif
    );

`ifdef MCA_SEQ_WARMUP_EN
    mca_control_sequencer #(
        .K(8), .N(2), .DSR(2), .CALC_CYCLES(3), .CNT_WIDTH(16)
    ) dut_c (
        .clk(clk), .resetn(resetn), .enable(enable), .s_in(s_in),
        .s_valid(s_valid), .clear_overrun(clear_overrun),
        .S_matrix(S_c), .start(start_c), .busy(busy_c),
        .overrun(ovr_c), .sample_count(cnt_c), .warm(warm_c)
    );
`endif

    always_comb begin
        pk_a = '0;
        pk_b = '0;
        for (int i = 0; i < 8; i++) begin
            pk_a[i] = S_a[i];
            pk_b[i] = S_b[i];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; enable = 1'b0; s_valid = 1'b0;
        clear_overrun = 1'b0; s_in = 2'b00;
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b0; s_valid = 1'b0;
        clear_overrun = 1'b0; s_in = 2'b00;
        step();
        step();
        checks++;
        if ({start_a, busy_a, ovr_a} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags_a: got %b expected 000", {start_a, busy_a, ovr_a});
        end
        checks++;
        if (cnt_a !== 16'd0 || pk_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_data_a: got cnt=%0d S=%h expected cnt=0 S=00", cnt_a, pk_a);
        end
        checks++;
        if ({start_b, busy_b, ovr_b} !== 3'b000 || cnt_b !== 16'd0 || pk_b !== 8'h00) begin
            errors++;
            $display("FAIL reset_b: got flags=%b cnt=%0d S=%h expected 000/0/00",
                     {start_b, busy_b, ovr_b}, cnt_b, pk_b);
        end
        resetn = 1'b1;
    endtask

    task automatic test_first_sample();
        logic [1:0] seq [4];
        seq = '{2'b01, 2'b10, 2'b11, 2'b00};
        enable = 1'b1; s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_in = seq[i];
            step();
            checks++;
            if (start_a !== (i == 3)) begin
                errors++;
                $display("FAIL first_start[%0d]: got %b expected %b", i, start_a, (i == 3));
            end
`ifdef MCA_SEQ_WARMUP_EN
            checks++;
            if (warm_a !== (i == 3)) begin
                errors++;
                $display("FAIL warm[%0d]: got %b expected %b", i, warm_a, (i == 3));
            end
            checks++;
            if (start_c !== (i == 3)) begin
                errors++;
                $display("FAIL warmup_dsr2_start[%0d]: got %b expected %b", i, start_c, (i == 3));
            end
`endif
        end
        checks++;
        if (pk_a !== 8'h6C) begin
            errors++;
            $display("FAIL first_snapshot: got %h expected 6c", pk_a);
        end
        checks++;
        if (busy_a !== 1'b1 || cnt_a !== 16'd1) begin
            errors++;
            $display("FAIL first_busy_count: got busy=%b cnt=%0d expected busy=1 cnt=1", busy_a, cnt_a);
        end
    endtask

    task automatic test_continuous();
        logic [1:0] seq [4];
        seq = '{2'b11, 2'b00, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin
            s_in = seq[i];
            step();
            checks++;
            if (start_a !== (i == 3) || busy_a !== ((i < 2) || (i == 3))) begin
                errors++;
                $display("FAIL cont_a[%0d]: got start=%b busy=%b expected start=%b busy=%b",
                         i, start_a, busy_a, (i == 3), ((i < 2) || (i == 3)));
            end
            checks++;
            if (start_b !== 1'b0) begin
                errors++;
                $display("FAIL cont_b_start[%0d]: got %b expected 0", i, start_b);
            end
        end
        checks++;
        if (pk_a !== 8'hC6 || cnt_a !== 16'd2 || ovr_a !== 1'b0) begin
            errors++;
            $display("FAIL second_sample_a: got S=%h cnt=%0d ovr=%b expected c6/2/0", pk_a, cnt_a, ovr_a);
        end
        checks++;
        if (pk_b !== 8'h6C || cnt_b !== 16'd1 || ovr_b !== 1'b1) begin
            errors++;
            $display("FAIL overrun_b: got S=%h cnt=%0d ovr=%b expected 6c/1/1", pk_b, cnt_b, ovr_b);
        end
    endtask

    task automatic test_clear_overrun();
        s_valid = 1'b0;
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        checks++;
        if (ovr_b !== 1'b0 || ovr_a !== 1'b0) begin
            errors++;
            $display("FAIL clear_overrun: got b=%b a=%b expected 0/0", ovr_b, ovr_a);
        end
    endtask

    task automatic test_set_wins();
        s_valid = 1'b1;
        s_in = 2'b01;
        for (int i = 0; i < 8; i++) begin
            clear_overrun = (i == 7);
            step();
            if (i == 3) begin
                checks++;
                if (start_b !== 1'b1 || cnt_b !== 16'd2) begin
                    errors++;
                    $display("FAIL restart_b: got start=%b cnt=%0d expected 1/2", start_b, cnt_b);
                end
            end
        end
        clear_overrun = 1'b0;
        checks++;
        if (ovr_b !== 1'b1 || cnt_b !== 16'd2) begin
            errors++;
            $display("FAIL set_wins: got ovr=%b cnt=%0d expected 1/2", ovr_b, cnt_b);
        end
    endtask

    task automatic test_valid_gaps();
        logic [1:0] seq [4];
        seq = '{2'b01, 2'b10, 2'b11, 2'b00};
        do_reset();
        enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_valid = (i % 2 == 1);
            s_in = s_valid ? seq[(i - 1) / 2] : 2'b11;
            step();
            checks++;
            if (start_a !== (i == 7)) begin
                errors++;
                $display("FAIL gap_start[%0d]: got %b expected %b", i, start_a, (i == 7));
            end
        end
        s_valid = 1'b1; s_in = 2'b11;
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (busy_a !== 1'b1 || start_a !== 1'b0 || pk_a !== 8'h6C) begin
                errors++;
                $display("FAIL hold[%0d]: got busy=%b start=%b S=%h expected 1/0/6c",
                         i, busy_a, start_a, pk_a);
            end
        end
        s_valid = 1'b0;
        enable = 1'b1;
        step();
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL extended_busy: got %b expected 1", busy_a);
        end
        step();
        checks++;
        if (busy_a !== 1'b0 || pk_a !== 8'h6C) begin
            errors++;
            $display("FAIL busy_end: got busy=%b S=%h expected 0/6c", busy_a, pk_a);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] seq [6];
        logic [1:0] seq2 [4];
        seq  = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b00};
        seq2 = '{2'b10, 2'b01, 2'b00, 2'b11};
        do_reset();
        enable = 1'b1; s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_in = seq[i];
            step();
        end
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy: got %b expected 1", busy_a);
        end
        resetn = 1'b0;
        s_in = 2'b11;
        step();
        resetn = 1'b1;
        checks++;
        if ({start_a, busy_a, ovr_a} !== 3'b000 || cnt_a !== 16'd0 || pk_a !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got flags=%b cnt=%0d S=%h expected 000/0/00",
                     {start_a, busy_a, ovr_a}, cnt_a, pk_a);
        end
        for (int i = 0; i < 4; i++) begin
            s_in = seq2[i];
            step();
            checks++;
            if (start_a !== (i == 3)) begin
                errors++;
                $display("FAIL post_reset_start[%0d]: got %b expected %b", i, start_a, (i == 3));
            end
        end
        checks++;
        if (pk_a !== 8'h93 || cnt_a !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_sample: got S=%h cnt=%0d expected 93/1", pk_a, cnt_a);
        end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_continuous();
        test_clear_overrun();
        test_set_wins();
        test_valid_gaps();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
